burst_memory: RTL and testbench
===============================

# burst_memory

Parametrised single-port synchronous memory with a burst command engine; the next generation of the CPU `Memory` block. A single command transfers len+1 words from a start address, stepping either linearly or wrapping within an aligned block. A write burst accepts one word per `wvalid` beat. A read burst streams one word per cycle with a `rvalid` qualifier. Separate read and write data ports replace the tri-state bus, so the block can be shared by the CPU datapath and a future DMA/loader.

## Interface
Parameters:
- AWIDTH, 5, address width; depth = 2^AWIDTH words
- DWIDTH, 8, data word width
- LWIDTH, 4, burst length field width; max burst = 2^LWIDTH beats
- WBLK_LOG2, 2, log2 of the wrap-block size used when `wrap`=1; must be less than or equal to AWIDTH

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- wr  in  1  start write burst; sampled only in IDLE
- rd  in  1  start read burst; sampled only in IDLE
- addr  in  AWIDTH  burst start address
- len  in  LWIDTH  burst beats minus one
- wrap  in  1  0 = linear addressing, 1 = wrap within aligned 2^WBLK_LOG2 block
- wdata  in  DWIDTH  write data
- wvalid  in  1  wdata valid for current write beat
- rdata  out  DWIDTH  read data, registered
- rvalid  out  1  rdata valid, one cycle per beat
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse marking burst completion
- err  out  1  one-cycle pulse on an illegal command

## Operation
- States: IDLE, WRITE, READ. Registered state, pointer `ptr` (AWIDTH bits), and beat counter `cnt` (LWIDTH bits).
- IDLE transitions:
  - wr=1, rd=0: ptr<=addr, cnt<=len, wrap mode latched, next state WRITE.
  - rd=1, wr=0: same latching, next state READ.
  - wr=rd=1: err<=1 for one cycle, stay in IDLE, no memory access.
  - Neither asserted: stay in IDLE.
- WRITE:
  - Edge with wvalid=1: mem[ptr]<=wdata, ptr advances, cnt decrements.
  - Edge with wvalid=0: nothing changes; busy stays high. There is no timeout.
  - Beat with cnt==0: last write, then state<=IDLE and done<=1.
- READ:
  - Every edge: rdata<=mem[ptr], rvalid<=1, ptr advances, cnt decrements. No backpressure.
  - Beat with cnt==0: state<=IDLE, and done<=1 coincides with the last rvalid.
- Pointer advance:
  - Linear: ptr+1 modulo 2^AWIDTH, so 31 wraps to 0 for AWIDTH=5.
  - Wrap: upper AWIDTH-WBLK_LOG2 bits held; lower WBLK_LOG2 bits incremented modulo 2^WBLK_LOG2.
- len does not need to be a power of two. A wrap burst longer than the block revisits addresses, and a later write overwrites an earlier one.
- wr/rd while busy are ignored; no error is flagged.
- A new command is accepted in the cycle `done` is high, because state is already IDLE.
- Memory array is not cleared by rst. Contents are undefined until written.
- rdata holds its last value when rvalid=0.

## Timing
- Reset values: rdata=0, rvalid=0, busy=0, done=0, err=0, state=IDLE, ptr=0, cnt=0.
- Reset mid-burst: the burst aborts on that edge. No further writes occur; already-written words persist.
- Read latency: command accepted at edge T0. First rvalid is visible after edge T1. The last beat is visible after edge T(len+1), with done in the same cycle. busy falls after T(len+1).
- Write: minimum len+1 cycles after the command edge. done is visible the cycle after the last wvalid beat.
- Write-then-read to the same address in back-to-back bursts returns the new data; there are no bypass hazards, because the ports are serialised by the FSM.
- busy is decoded from the state register (glitch-free, no extra latency).

## Structure
- Shared package `mem_pkg`: state encoding constants (IDLE/WRITE/READ) and the wrap-mode constant, reused by the future DMA and the bench.
- Sub-module `burst_addr_gen`: holds ptr/cnt and computes the next address in linear or wrap mode, and the last-beat flag. The top level keeps the FSM, array and output registers.

## Test plan
1. Single-beat write: addr=0, len=0, data=8'hFF. Then single-beat read of addr 0. Expect rdata=8'hFF with one rvalid cycle, done coincident, and err never asserted.
2. Linear wrap-around: write addr=30, len=3, data 1,2,3,4. Expect mem[30]=1, mem[31]=2, mem[0]=3, mem[1]=4. Read the same burst and expect 1,2,3,4 on consecutive cycles.
3. Wrap mode: WBLK_LOG2=2, write addr=6, len=3, wrap=1, data A,B,C,D. Expect addresses 6,7,4,5. A linear read from addr 4 with len=3 returns C,D,A,B.
4. Write gaps: len=3 with wvalid low for 2 cycles after beat 1. Expect busy held, pointer frozen, all 4 words correct, and done 6 cycles after the command.
5. Illegal command: wr=rd=1 in IDLE. Expect a single err pulse, busy=0, and memory unchanged on readback.
6. Reset mid-write: len=7 from addr 8, rst asserted after 3 beats. Expect all outputs at reset values and addresses 11–15 to retain their old data. Full addressing sweep: write ascending data to descending addresses 31..1, then read back.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the burst memory family.
// Holds the burst FSM state encoding and the address-mode constants,
// so that the memory, a future DMA engine and the bench agree on them.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // Address stepping mode captured with each burst command.
    localparam logic ADDR_LINEAR = 1'b0;
    localparam logic ADDR_WRAP   = 1'b1;

endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: burst pointer and beat counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture addr/len/wrap as a new burst
//   step          advance pointer and decrement beat counter
//   addr, len     burst start address and beats-minus-one
//   wrap          ADDR_WRAP = stay inside aligned 2^WBLK_LOG2 block
//   ptr           current word address
//   last          current beat is the final one of the burst
module burst_addr_gen
    import mem_pkg::*;
#(
    parameter int AWIDTH    = 5,
    parameter int LWIDTH    = 4,
    parameter int WBLK_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [AWIDTH-1:0] addr,
    input  logic [LWIDTH-1:0] len,
    input  logic              wrap,
    output logic [AWIDTH-1:0] ptr,
    output logic              last
);

    // Bits of the address that move in wrap mode; the rest stay fixed.
    localparam logic [AWIDTH-1:0] WRAP_MASK = {AWIDTH{1'b1}} >> (AWIDTH - WBLK_LOG2);

    logic [LWIDTH-1:0] cnt;
    logic              wrap_q;
    logic [AWIDTH-1:0] ptr_inc;
    logic [AWIDTH-1:0] ptr_next;

    assign ptr_inc  = ptr + 1'b1;
    assign ptr_next = (wrap_q == ADDR_WRAP) ? ((ptr & ~WRAP_MASK) | (ptr_inc & WRAP_MASK))
                                            : ptr_inc;
    assign last     = (cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            cnt    <= '0;
            wrap_q <= ADDR_LINEAR;
        end else if (load) begin
            ptr    <= addr;
            cnt    <= len;
            wrap_q <= wrap;
        end else if (step) begin
            ptr    <= ptr_next;
            cnt    <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/burst_memory.sv
// burst_memory: single-port synchronous memory with a burst command engine.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr, rd        start write / read burst (sampled only when idle)
//   addr, len     burst start address, beats minus one
//   wrap          0 = linear, 1 = wrap inside aligned 2^WBLK_LOG2 block
//   wdata, wvalid write data and its beat qualifier
//   rdata, rvalid registered read data and its one-cycle-per-beat qualifier
//   busy          engine is in a burst
//   done          one-cycle pulse at burst completion
//   err           one-cycle pulse when wr and rd arrive together
module burst_memory
    import mem_pkg::*;
#(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 8,
    parameter int LWIDTH    = 4,
    parameter int WBLK_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [AWIDTH-1:0] addr,
    input  logic [LWIDTH-1:0] len,
    input  logic              wrap,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              wvalid,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << AWIDTH;

    state_t            state, state_next;
    logic              load, step, mem_we, mem_re;
    logic              done_next, err_next;
    logic [AWIDTH-1:0] ptr;
    logic              last;
    logic [DWIDTH-1:0] mem [DEPTH];

    burst_addr_gen #(
        .AWIDTH   (AWIDTH),
        .LWIDTH   (LWIDTH),
        .WBLK_LOG2(WBLK_LOG2)
    ) u_addr_gen (
        .clk (clk),
        .rst (rst),
        .load(load),
        .step(step),
        .addr(addr),
        .len (len),
        .wrap(wrap),
        .ptr (ptr),
        .last(last)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (wr && rd) begin
                    err_next = 1'b1;
                end else if (wr) begin
                    load       = 1'b1;
                    state_next = WRITE;
                end else if (rd) begin
                    load       = 1'b1;
                    state_next = READ;
                end
            end
            WRITE: begin
                // A missing wvalid simply stalls the burst.
                if (wvalid) begin
                    mem_we = 1'b1;
                    step   = 1'b1;
                    if (last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            READ: begin
                mem_re = 1'b1;
                step   = 1'b1;
                if (last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the array has no reset so it maps onto RAM; rst only gates
    // the write so a burst aborted by reset stops on that very edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= mem_re;
            done   <= done_next;
            err    <= err_next;
            if (mem_re) rdata <= mem[ptr];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: directed plus randomized bursts against a word-level
// reference model of the memory and the burst addressing rules.
module tb_burst_memory;

    logic       clk = 1'b0;
    logic       rst, wr, rd, wrap, wvalid;
    logic [4:0] addr;
    logic [3:0] len;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, busy, done, err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [32];
    logic [7:0] wbuf [16];

    burst_memory #(
        .AWIDTH(5), .DWIDTH(8), .LWIDTH(4), .WBLK_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .len(len),
        .wrap(wrap), .wdata(wdata), .wvalid(wvalid), .rdata(rdata),
        .rvalid(rvalid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Address of beat i of a burst, straight from the addressing rules.
    function automatic int addr_at(input int a, input int w, input int i);
        if (w != 0) return (a / 4) * 4 + ((a % 4) + i) % 4;
        return (a + i) % 32;
    endfunction

    // Write burst from wbuf; gap_len idle cycles inserted before beat gap_at.
    // edges = clock edges from the command edge until done is visible.
    task automatic do_write(input int a, input int l, input int w,
                            input int gap_at, input int gap_len, output int edges);
        wr = 1'b1; addr = 5'(a); len = 4'(l); wrap = w[0];
        tick();
        wr = 1'b0;
        edges = 0;
        check("wr_busy_start", busy, 1);
        for (int i = 0; i <= l; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    wvalid = 1'b0;
                    rd = 1'($urandom_range(0, 1));  // must be ignored while busy
                    tick();
                    edges++;
                    check("gap_busy", busy, 1);
                    check("gap_done", done, 0);
                end
                rd = 1'b0;
            end
            wvalid = 1'b1;
            wdata  = wbuf[i];
            tick();
            edges++;
            ref_mem[addr_at(a, w, i)] = wbuf[i];
            check("wr_done", done, (i == l));
        end
        wvalid = 1'b0;
        check("wr_busy_end", busy, 0);
        check("wr_err", err, 0);
    endtask

    task automatic do_read(input int a, input int l, input int w);
        logic [7:0] last_exp;
        last_exp = '0;
        rd = 1'b1; addr = 5'(a); len = 4'(l); wrap = w[0];
        tick();
        rd = 1'b0;
        check("rd_busy_start", busy, 1);
        check("rd_rvalid_first", rvalid, 0);
        for (int i = 0; i <= l; i++) begin
            tick();
            last_exp = ref_mem[addr_at(a, w, i)];
            check("rd_rvalid", rvalid, 1);
            check("rd_data", rdata, last_exp);
            check("rd_done", done, (i == l));
            check("rd_err", err, 0);
        end
        tick();
        check("rd_rvalid_end", rvalid, 0);
        check("rd_busy_end", busy, 0);
        check("rd_done_end", done, 0);
        check("rd_hold", rdata, last_exp);
    endtask

    initial begin
        int edges;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; wrap = 1'b0; wvalid = 1'b0;
        addr = '0; len = '0; wdata = '0;
        tick();
        tick();
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Single-beat write and read at address 0.
        wbuf[0] = 8'hFF;
        do_write(0, 0, 0, 99, 0, edges);
        do_read(0, 0, 0);

        // Linear burst across the top of the address space.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        do_write(30, 3, 0, 99, 0, edges);
        do_read(30, 3, 0);

        // Wrap burst inside block 4..7, then a linear read of that block.
        wbuf[0] = 8'h0A; wbuf[1] = 8'h0B; wbuf[2] = 8'h0C; wbuf[3] = 8'h0D;
        do_write(6, 3, 1, 99, 0, edges);
        do_read(4, 3, 0);
        do_read(6, 3, 1);

        // Two idle cycles after the first beat: done 6 edges after command.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'h40 + i);
        do_write(12, 3, 0, 1, 2, edges);
        check("gap_done_edges", edges, 6);
        do_read(12, 3, 0);

        // Illegal command: wr and rd together, with write data on offer.
        wr = 1'b1; rd = 1'b1; addr = 5'd0; len = 4'd1; wvalid = 1'b1; wdata = 8'h99;
        tick();
        wr = 1'b0; rd = 1'b0; wvalid = 1'b0;
        check("ill_err", err, 1);
        check("ill_busy", busy, 0);
        tick();
        check("ill_err_pulse", err, 0);
        check("ill_busy_after", busy, 0);
        do_read(0, 1, 0);

        // Sweep: ascending data to descending addresses 31..1.
        for (int k = 0; k < 31; k++) begin
            wbuf[0] = 8'(k + 1);
            do_write(31 - k, 0, 0, 99, 0, edges);
        end
        do_read(0, 15, 0);
        do_read(16, 15, 0);

        // Reset after three beats of an 8-beat write from address 8.
        for (int i = 0; i < 3; i++) wbuf[i] = 8'(8'hC0 + i);
        wr = 1'b1; addr = 5'd8; len = 4'd7; wrap = 1'b0;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = wbuf[i];
            tick();
            ref_mem[8 + i] = wbuf[i];
        end
        rst = 1'b1; wvalid = 1'b1; wdata = 8'h5A;
        tick();
        rst = 1'b0; wvalid = 1'b0;
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        tick();
        check("post_rst_busy", busy, 0);
        do_read(8, 7, 0);

        // Randomized write/read bursts, every word already defined.
        for (int n = 0; n < 25; n++) begin
            int a, l, w, ga, gl;
            a  = $urandom_range(0, 31);
            l  = $urandom_range(0, 15);
            w  = $urandom_range(0, 1);
            ga = $urandom_range(0, l + 1);
            gl = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_write(a, l, w, ga, gl, edges);
            do_read($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
